camera_emulator: RTL and testbench
==================================

CAMERA_EMULATOR -- requirements
Module: camera_emulator

Interface
REQ-001 SHALL have parameter DATA_W, default 12, pixel data width.
REQ-002 SHALL have parameter CNT_W, default 12, width of size/blanking/position counters.
REQ-003 SHALL have one clock and a synchronous, active-high reset.
REQ-004 clock  in  1  single clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 in_start  in  1  one-cycle request to begin a frame sequence.
REQ-007 in_continuous  in  1  1 = free-run frames back to back; 0 = single frame.
REQ-008 in_width, in_height  in  CNT_W each  active pixels per line, lines per frame.
REQ-009 in_hblank, in_vblank  in  CNT_W each  line-gap cycles, frame-gap cycles.
REQ-010 out_frame_valid, out_line_valid  out  1 each  sensor-style FVAL/LVAL.
REQ-011 out_data  out  DATA_W  pixel value, qualified by out_line_valid.
REQ-012 out_busy  out  1  high whenever state is not IDLE.
REQ-013 out_frame_done  out  1  one-cycle pulse at the end of each frame's vblank.

Function
REQ-014 SHALL implement FSM states IDLE, LINE, HBLANK, VBLANK.
REQ-015 SHALL latch width/height/hblank/vblank/continuous on entry to LINE at row 0; mid-frame input changes are ignored.
REQ-016 In IDLE, in_start=1 with width>0 and height>0 SHALL enter LINE next cycle at x=0, y=0; zero width or height SHALL keep IDLE.
REQ-017 LINE: frame_valid=1, line_valid=1, one pixel per cycle; after x=width-1, go to HBLANK if y<height-1, else VBLANK.
REQ-018 HBLANK: frame_valid=1, line_valid=0 for max(hblank,1) cycles, then LINE with x=0, y=y+1.
REQ-019 VBLANK: frame_valid=0, line_valid=0 for max(vblank,1) cycles; out_frame_done pulses in the last VBLANK cycle.
REQ-020 After VBLANK: latched continuous=1 SHALL go to LINE with fresh config latch; else IDLE.
REQ-021 in_start while busy SHALL be ignored; deasserting in_continuous SHALL stop after the current frame.
REQ-022 All outputs SHALL be registered; out_data SHALL be 0 whenever out_line_valid=0.
REQ-023 Pattern data SHALL align with the same cycle's line_valid; x and y SHALL never exceed width-1, height-1.

Reset
REQ-024 Reset SHALL force IDLE, x=y=0, all outputs 0, regardless of current state, with no frame_done pulse.

Configuration
REQ-025 With CAMERA_EMULATOR_BAYER_EN defined: out_data = Bayer levels by parity; even row: even col G, odd col R; odd row: even col B, odd col G.
REQ-026 Without CAMERA_EMULATOR_BAYER_EN: out_data = (x + y) truncated to DATA_W (ramp pattern).

Structure
REQ-027 Shared package camera_emulator_pkg SHALL hold the state enum and constants BAYER_R=12'h800, BAYER_G=12'h400, BAYER_B=12'h200, MIN_BLANK=1.
REQ-028 Pattern generation SHALL be a sub-module camera_pattern_gen (x, y in; data out, combinational); FSM and counters stay in camera_emulator.

Verification
REQ-029 Ramp, width=4, height=2, hblank=2, vblank=3, single frame, start -> LVAL 4 high, 2 low, 4 high; FVAL 10 cycles; data 0,1,2,3 then 1,2,3,4; done pulse 3 cycles after FVAL falls begins; then IDLE.
REQ-030 Bayer, width=2, height=2 -> data 400,800 then 200,400 (hex).
REQ-031 continuous=1, 3 frames, then clear -> exactly 3 frame_done pulses; 4th frame only if the clear falls after frame 4's latch.
REQ-032 hblank=0, vblank=0 -> 1-cycle gaps; width=0 with start -> out_busy stays 0.
REQ-033 reset asserted mid-LINE (x=2, y=1) -> next cycle all outputs 0, state IDLE; a later start begins a frame at x=0, y=0.
REQ-034 Width changed from 4 to 8 mid-frame -> current frame keeps 4-pixel lines; next continuous frame uses 8.

Source files
------------

// File: rtl/camera_emulator_pkg.sv
// Shared types and constants for the camera emulator: FSM state encoding,
// Bayer test levels and the minimum blanking length.
package camera_emulator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LINE   = 2'd1,
        ST_HBLANK = 2'd2,
        ST_VBLANK = 2'd3
    } state_t;

    localparam logic [11:0] BAYER_R   = 12'h800;
    localparam logic [11:0] BAYER_G   = 12'h400;
    localparam logic [11:0] BAYER_B   = 12'h200;
    localparam int          MIN_BLANK = 1;

endpackage

// File: rtl/camera_pattern_gen.sv
// Combinational test-pattern source: (x + y) ramp by default, or Bayer
// levels by pixel parity when CAMERA_EMULATOR_BAYER_EN is defined.
module camera_pattern_gen
    import camera_emulator_pkg::*;
#(
    parameter int DATA_W = 12,
    parameter int CNT_W  = 12
) (
    input  logic [CNT_W-1:0]  i_x,
    input  logic [CNT_W-1:0]  i_y,
    output logic [DATA_W-1:0] o_data
);

`ifdef CAMERA_EMULATOR_BAYER_EN
    // Only the parity bits select the colour site.
    logic w_unused_bits;
    assign w_unused_bits = ^{i_x[CNT_W-1:1], i_y[CNT_W-1:1]};

    always_comb begin
        o_data = DATA_W'(BAYER_G);
        case ({i_y[0], i_x[0]})
            2'b00:   o_data = DATA_W'(BAYER_G);
            2'b01:   o_data = DATA_W'(BAYER_R);
            2'b10:   o_data = DATA_W'(BAYER_B);
            default: o_data = DATA_W'(BAYER_G);
        endcase
    end
`else
    assign o_data = DATA_W'(i_x) + DATA_W'(i_y);
`endif

endmodule

// File: rtl/camera_emulator.sv
// Image-sensor style frame generator with FVAL/LVAL timing and a test pattern.
// Optional macro CAMERA_EMULATOR_BAYER_EN selects Bayer data instead of a ramp.
module camera_emulator
    import camera_emulator_pkg::*;
#(
    parameter int DATA_W = 12,
    parameter int CNT_W  = 12
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_start,
    input  logic              in_continuous,
    input  logic [CNT_W-1:0]  in_width,
    input  logic [CNT_W-1:0]  in_height,
    input  logic [CNT_W-1:0]  in_hblank,
    input  logic [CNT_W-1:0]  in_vblank,
    output logic              out_frame_valid,
    output logic              out_line_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_busy,
    output logic              out_frame_done
);

    // state     | meaning
    // IDLE      | waiting for in_start with a non-empty frame size
    // LINE      | streaming one pixel per cycle, FVAL=1 LVAL=1
    // HBLANK    | gap between lines, FVAL=1 LVAL=0
    // VBLANK    | gap after the last line, FVAL=0; frame_done in its last cycle

    state_t             r_state;
    logic [CNT_W-1:0]   r_x;
    logic [CNT_W-1:0]   r_y;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   r_width;
    logic [CNT_W-1:0]   r_height;
    logic [CNT_W-1:0]   r_hblank;
    logic [CNT_W-1:0]   r_vblank;
    logic               r_cont;

    logic               r_fval;
    logic               r_lval;
    logic [DATA_W-1:0]  r_data;
    logic               r_busy;
    logic               r_done;

    state_t             w_next_state;
    logic [CNT_W-1:0]   w_next_x;
    logic [CNT_W-1:0]   w_next_y;
    logic [CNT_W-1:0]   w_next_cnt;
    logic               w_latch;
    logic               w_cfg_ok;
    logic [CNT_W-1:0]   w_hb_len;
    logic [CNT_W-1:0]   w_vb_len;
    logic [DATA_W-1:0]  w_pix;

    assign w_cfg_ok = (in_width != '0) && (in_height != '0);

    // Blanking down-counters load length-1 and terminate at zero; a zero
    // programmed gap still costs one cycle.
    assign w_hb_len = (r_hblank < CNT_W'(MIN_BLANK)) ? CNT_W'(MIN_BLANK - 1)
                                                     : r_hblank - CNT_W'(1);
    assign w_vb_len = (r_vblank < CNT_W'(MIN_BLANK)) ? CNT_W'(MIN_BLANK - 1)
                                                     : r_vblank - CNT_W'(1);

    always_comb begin
        w_next_state = r_state;
        w_next_x     = r_x;
        w_next_y     = r_y;
        w_next_cnt   = r_cnt;
        w_latch      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (in_start && w_cfg_ok) begin
                    w_next_state = ST_LINE;
                    w_next_x     = '0;
                    w_next_y     = '0;
                    w_latch      = 1'b1;
                end
            end
            ST_LINE: begin
                if (r_x == r_width - CNT_W'(1)) begin
                    if (r_y == r_height - CNT_W'(1)) begin
                        w_next_state = ST_VBLANK;
                        w_next_cnt   = w_vb_len;
                    end else begin
                        w_next_state = ST_HBLANK;
                        w_next_cnt   = w_hb_len;
                    end
                end else begin
                    w_next_x = r_x + CNT_W'(1);
                end
            end
            ST_HBLANK: begin
                if (r_cnt == '0) begin
                    w_next_state = ST_LINE;
                    w_next_x     = '0;
                    w_next_y     = r_y + CNT_W'(1);
                end else begin
                    w_next_cnt = r_cnt - CNT_W'(1);
                end
            end
            ST_VBLANK: begin
                if (r_cnt == '0) begin
                    w_next_x = '0;
                    w_next_y = '0;
                    // Free-run needs both the latched mode and the live enable,
                    // so clearing in_continuous stops after the current frame.
                    if (r_cont && in_continuous && w_cfg_ok) begin
                        w_next_state = ST_LINE;
                        w_latch      = 1'b1;
                    end else begin
                        w_next_state = ST_IDLE;
                    end
                end else begin
                    w_next_cnt = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_next_state = ST_IDLE;
                w_next_x     = '0;
                w_next_y     = '0;
            end
        endcase
    end

    camera_pattern_gen #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_pattern (
        .i_x    (w_next_x),
        .i_y    (w_next_y),
        .o_data (w_pix)
    );

    // Outputs are registered from next-state values so they line up with the
    // state and coordinates held in the same cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_x      <= '0;
            r_y      <= '0;
            r_cnt    <= '0;
            r_width  <= '0;
            r_height <= '0;
            r_hblank <= '0;
            r_vblank <= '0;
            r_cont   <= 1'b0;
            r_fval   <= 1'b0;
            r_lval   <= 1'b0;
            r_data   <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_x     <= w_next_x;
            r_y     <= w_next_y;
            r_cnt   <= w_next_cnt;
            if (w_latch) begin
                r_width  <= in_width;
                r_height <= in_height;
                r_hblank <= in_hblank;
                r_vblank <= in_vblank;
                r_cont   <= in_continuous;
            end
            r_fval <= (w_next_state == ST_LINE) || (w_next_state == ST_HBLANK);
            r_lval <= (w_next_state == ST_LINE);
            r_data <= (w_next_state == ST_LINE) ? w_pix : '0;
            r_busy <= (w_next_state != ST_IDLE);
            r_done <= (w_next_state == ST_VBLANK) && (w_next_cnt == '0);
        end
    end

    assign out_frame_valid = r_fval;
    assign out_line_valid  = r_lval;
    assign out_data        = r_data;
    assign out_busy        = r_busy;
    assign out_frame_done  = r_done;

endmodule

// File: tb/tb_camera_emulator.sv
// Directed self-checking bench for camera_emulator (ramp or Bayer build).
module tb_camera_emulator;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_start;
    logic        in_continuous;
    logic [11:0] in_width;
    logic [11:0] in_height;
    logic [11:0] in_hblank;
    logic [11:0] in_vblank;
    logic        out_frame_valid;
    logic        out_line_valid;
    logic [11:0] out_data;
    logic        out_busy;
    logic        out_frame_done;

    int n_checks = 0;
    int n_errors = 0;

    logic        tr_fv[64];
    logic        tr_lv[64];
    logic        tr_dn[64];
    logic        tr_bz[64];
    logic [11:0] tr_dt[64];

    camera_emulator #(.DATA_W(12), .CNT_W(12)) dut (
        .clock           (clock),
        .reset           (reset),
        .in_start        (in_start),
        .in_continuous   (in_continuous),
        .in_width        (in_width),
        .in_height       (in_height),
        .in_hblank       (in_hblank),
        .in_vblank       (in_vblank),
        .out_frame_valid (out_frame_valid),
        .out_line_valid  (out_line_valid),
        .out_data        (out_data),
        .out_busy        (out_busy),
        .out_frame_done  (out_frame_done)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic sample(input int c);
        tr_fv[c] = out_frame_valid;
        tr_lv[c] = out_line_valid;
        tr_dn[c] = out_frame_done;
        tr_bz[c] = out_busy;
        tr_dt[c] = out_data;
    endtask

    task automatic setup(input int w, input int h, input int hb, input int vb, input bit cont);
        in_width      = 12'(w);
        in_height     = 12'(h);
        in_hblank     = 12'(hb);
        in_vblank     = 12'(vb);
        in_continuous = cont;
    endtask

    task automatic test_reset;
        reset    = 1'b1;
        in_start = 1'b1;
        setup(4, 2, 2, 3, 1'b0);
        repeat (3) @(negedge clock);
        n_checks++; if (out_busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got %b want 0", out_busy); end
        n_checks++; if (out_frame_valid !== 1'b0) begin n_errors++; $display("FAIL reset_fval got %b want 0", out_frame_valid); end
        n_checks++; if (out_line_valid !== 1'b0) begin n_errors++; $display("FAIL reset_lval got %b want 0", out_line_valid); end
        n_checks++; if (out_data !== 12'h000) begin n_errors++; $display("FAIL reset_data got %h want 000", out_data); end
        n_checks++; if (out_frame_done !== 1'b0) begin n_errors++; $display("FAIL reset_done got %b want 0", out_frame_done); end
        in_start = 1'b0;
        reset    = 1'b0;
        @(negedge clock);
        n_checks++; if (out_busy !== 1'b0) begin n_errors++; $display("FAIL post_reset_busy got %b want 0", out_busy); end
    endtask

    // 4x2, hblank 2, vblank 3, single frame; a start during HBLANK is ignored.
    task automatic test_ramp_frame;
        int exp_lv[16] = '{1,1,1,1,0,0,1,1,1,1,0,0,0,0,0,0};
        int exp_fv[16] = '{1,1,1,1,1,1,1,1,1,1,0,0,0,0,0,0};
        int exp_dn[16] = '{0,0,0,0,0,0,0,0,0,0,0,0,1,0,0,0};
        int exp_bz[16] = '{1,1,1,1,1,1,1,1,1,1,1,1,1,0,0,0};
        int exp_dt[16];
`ifdef CAMERA_EMULATOR_BAYER_EN
        exp_dt = '{'h400,'h800,'h400,'h800,0,0,'h200,'h400,'h200,'h400,0,0,0,0,0,0};
`else
        exp_dt = '{0,1,2,3,0,0,1,2,3,4,0,0,0,0,0,0};
`endif
        setup(4, 2, 2, 3, 1'b0);
        @(negedge clock);
        in_start = 1'b1;
        for (int c = 0; c < 16; c++) begin
            @(negedge clock);
            sample(c);
            if (c == 0) in_start = 1'b0;
            if (c == 5) in_start = 1'b1;
            if (c == 6) in_start = 1'b0;
        end
        for (int c = 0; c < 16; c++) begin
            n_checks++; if (tr_lv[c] !== 1'(exp_lv[c])) begin n_errors++; $display("FAIL ramp_lval[%0d] got %b want %0d", c, tr_lv[c], exp_lv[c]); end
            n_checks++; if (tr_fv[c] !== 1'(exp_fv[c])) begin n_errors++; $display("FAIL ramp_fval[%0d] got %b want %0d", c, tr_fv[c], exp_fv[c]); end
            n_checks++; if (tr_dn[c] !== 1'(exp_dn[c])) begin n_errors++; $display("FAIL ramp_done[%0d] got %b want %0d", c, tr_dn[c], exp_dn[c]); end
            n_checks++; if (tr_bz[c] !== 1'(exp_bz[c])) begin n_errors++; $display("FAIL ramp_busy[%0d] got %b want %0d", c, tr_bz[c], exp_bz[c]); end
            n_checks++; if (tr_dt[c] !== 12'(exp_dt[c])) begin n_errors++; $display("FAIL ramp_data[%0d] got %h want %h", c, tr_dt[c], 12'(exp_dt[c])); end
        end
    endtask

    // 2x2 with zero blanking: each gap still lasts exactly one cycle.
    task automatic test_min_blank;
        int exp_lv[8] = '{1,1,0,1,1,0,0,0};
        int exp_fv[8] = '{1,1,1,1,1,0,0,0};
        int exp_dn[8] = '{0,0,0,0,0,1,0,0};
        int exp_bz[8] = '{1,1,1,1,1,1,0,0};
        int exp_dt[8];
`ifdef CAMERA_EMULATOR_BAYER_EN
        exp_dt = '{'h400,'h800,0,'h200,'h400,0,0,0};
`else
        exp_dt = '{0,1,0,1,2,0,0,0};
`endif
        setup(2, 2, 0, 0, 1'b0);
        @(negedge clock);
        in_start = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clock);
            sample(c);
            if (c == 0) in_start = 1'b0;
        end
        for (int c = 0; c < 8; c++) begin
            n_checks++; if (tr_lv[c] !== 1'(exp_lv[c])) begin n_errors++; $display("FAIL minblank_lval[%0d] got %b want %0d", c, tr_lv[c], exp_lv[c]); end
            n_checks++; if (tr_fv[c] !== 1'(exp_fv[c])) begin n_errors++; $display("FAIL minblank_fval[%0d] got %b want %0d", c, tr_fv[c], exp_fv[c]); end
            n_checks++; if (tr_dn[c] !== 1'(exp_dn[c])) begin n_errors++; $display("FAIL minblank_done[%0d] got %b want %0d", c, tr_dn[c], exp_dn[c]); end
            n_checks++; if (tr_bz[c] !== 1'(exp_bz[c])) begin n_errors++; $display("FAIL minblank_busy[%0d] got %b want %0d", c, tr_bz[c], exp_bz[c]); end
            n_checks++; if (tr_dt[c] !== 12'(exp_dt[c])) begin n_errors++; $display("FAIL minblank_data[%0d] got %h want %h", c, tr_dt[c], 12'(exp_dt[c])); end
        end
    endtask

    task automatic test_zero_size;
        for (int k = 0; k < 2; k++) begin
            if (k == 0) setup(0, 2, 1, 1, 1'b0);
            else        setup(3, 0, 1, 1, 1'b0);
            @(negedge clock);
            in_start = 1'b1;
            for (int c = 0; c < 4; c++) begin
                @(negedge clock);
                in_start = 1'b0;
                n_checks++; if (out_busy !== 1'b0) begin n_errors++; $display("FAIL zero_size%0d_busy[%0d] got %b want 0", k, c, out_busy); end
                n_checks++; if (out_frame_valid !== 1'b0) begin n_errors++; $display("FAIL zero_size%0d_fval[%0d] got %b want 0", k, c, out_frame_valid); end
            end
        end
    endtask

    // 4x2 frames of 10 cycles back to back; continuous cleared during frame 3.
    task automatic test_continuous;
        int ndone;
        int exp_dt0;
`ifdef CAMERA_EMULATOR_BAYER_EN
        exp_dt0 = 'h400;
`else
        exp_dt0 = 0;
`endif
        setup(4, 2, 1, 1, 1'b1);
        @(negedge clock);
        in_start = 1'b1;
        for (int c = 0; c < 45; c++) begin
            @(negedge clock);
            sample(c);
            if (c == 0)  in_start = 1'b0;
            if (c == 25) in_continuous = 1'b0;
        end
        ndone = 0;
        for (int c = 0; c < 45; c++) if (tr_dn[c] === 1'b1) ndone++;
        n_checks++; if (ndone != 3) begin n_errors++; $display("FAIL cont_done_count got %0d want 3", ndone); end
        n_checks++; if (tr_dn[9] !== 1'b1) begin n_errors++; $display("FAIL cont_done_f1 got %b want 1", tr_dn[9]); end
        n_checks++; if (tr_dn[19] !== 1'b1) begin n_errors++; $display("FAIL cont_done_f2 got %b want 1", tr_dn[19]); end
        n_checks++; if (tr_dn[29] !== 1'b1) begin n_errors++; $display("FAIL cont_done_f3 got %b want 1", tr_dn[29]); end
        n_checks++; if (tr_fv[10] !== 1'b1) begin n_errors++; $display("FAIL cont_f2_fval got %b want 1", tr_fv[10]); end
        n_checks++; if (tr_dt[10] !== 12'(exp_dt0)) begin n_errors++; $display("FAIL cont_f2_first_pixel got %h want %h", tr_dt[10], 12'(exp_dt0)); end
        n_checks++; if (tr_bz[29] !== 1'b1) begin n_errors++; $display("FAIL cont_busy_f3_end got %b want 1", tr_bz[29]); end
        n_checks++; if (tr_bz[30] !== 1'b0) begin n_errors++; $display("FAIL cont_busy_after got %b want 0", tr_bz[30]); end
    endtask

    // Width 4 -> 8 mid-frame: frame 1 keeps 4-pixel lines, frame 2 uses 8.
    task automatic test_width_change;
        int n1;
        int n2;
        int ndone;
        int exp_dt17;
`ifdef CAMERA_EMULATOR_BAYER_EN
        exp_dt17 = 'h800;
`else
        exp_dt17 = 7;
`endif
        setup(4, 2, 1, 1, 1'b1);
        @(negedge clock);
        in_start = 1'b1;
        for (int c = 0; c < 35; c++) begin
            @(negedge clock);
            sample(c);
            if (c == 0)  in_start = 1'b0;
            if (c == 2)  in_width = 12'd8;
            if (c == 12) in_continuous = 1'b0;
        end
        n1 = 0; n2 = 0; ndone = 0;
        for (int c = 0; c < 10; c++)  if (tr_lv[c] === 1'b1) n1++;
        for (int c = 10; c < 28; c++) if (tr_lv[c] === 1'b1) n2++;
        for (int c = 0; c < 35; c++)  if (tr_dn[c] === 1'b1) ndone++;
        n_checks++; if (n1 != 8) begin n_errors++; $display("FAIL wchg_f1_pixels got %0d want 8", n1); end
        n_checks++; if (tr_lv[4] !== 1'b0) begin n_errors++; $display("FAIL wchg_f1_hblank got %b want 0", tr_lv[4]); end
        n_checks++; if (n2 != 16) begin n_errors++; $display("FAIL wchg_f2_pixels got %0d want 16", n2); end
        n_checks++; if (tr_lv[17] !== 1'b1) begin n_errors++; $display("FAIL wchg_f2_x7_lval got %b want 1", tr_lv[17]); end
        n_checks++; if (tr_dt[17] !== 12'(exp_dt17)) begin n_errors++; $display("FAIL wchg_f2_x7_data got %h want %h", tr_dt[17], 12'(exp_dt17)); end
        n_checks++; if (tr_lv[18] !== 1'b0) begin n_errors++; $display("FAIL wchg_f2_hblank got %b want 0", tr_lv[18]); end
        n_checks++; if (tr_dn[27] !== 1'b1) begin n_errors++; $display("FAIL wchg_f2_done got %b want 1", tr_dn[27]); end
        n_checks++; if (ndone != 2) begin n_errors++; $display("FAIL wchg_done_count got %0d want 2", ndone); end
        n_checks++; if (tr_bz[28] !== 1'b0) begin n_errors++; $display("FAIL wchg_busy_after got %b want 0", tr_bz[28]); end
        in_width = 12'd4;
    endtask

    // Reset at x=2, y=1 aborts the frame; the next start begins at x=0, y=0.
    task automatic test_reset_mid_line;
        int exp_x2y1;
        int exp_row0[4];
`ifdef CAMERA_EMULATOR_BAYER_EN
        exp_x2y1 = 'h200;
        exp_row0 = '{'h400,'h800,'h400,'h800};
`else
        exp_x2y1 = 3;
        exp_row0 = '{0,1,2,3};
`endif
        setup(4, 2, 2, 3, 1'b0);
        @(negedge clock);
        in_start = 1'b1;
        for (int c = 0; c < 9; c++) begin
            @(negedge clock);
            sample(c);
            if (c == 0) in_start = 1'b0;
        end
        n_checks++; if (tr_dt[8] !== 12'(exp_x2y1)) begin n_errors++; $display("FAIL rstmid_pre_data got %h want %h", tr_dt[8], 12'(exp_x2y1)); end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        n_checks++; if (out_busy !== 1'b0) begin n_errors++; $display("FAIL rstmid_busy got %b want 0", out_busy); end
        n_checks++; if (out_frame_valid !== 1'b0) begin n_errors++; $display("FAIL rstmid_fval got %b want 0", out_frame_valid); end
        n_checks++; if (out_line_valid !== 1'b0) begin n_errors++; $display("FAIL rstmid_lval got %b want 0", out_line_valid); end
        n_checks++; if (out_data !== 12'h000) begin n_errors++; $display("FAIL rstmid_data got %h want 000", out_data); end
        n_checks++; if (out_frame_done !== 1'b0) begin n_errors++; $display("FAIL rstmid_done got %b want 0", out_frame_done); end
        @(negedge clock);
        n_checks++; if (out_busy !== 1'b0) begin n_errors++; $display("FAIL rstmid_idle got %b want 0", out_busy); end
        in_start = 1'b1;
        for (int c = 0; c < 16; c++) begin
            @(negedge clock);
            sample(c);
            if (c == 0) in_start = 1'b0;
        end
        for (int c = 0; c < 4; c++) begin
            n_checks++; if (tr_lv[c] !== 1'b1) begin n_errors++; $display("FAIL rstmid_restart_lval[%0d] got %b want 1", c, tr_lv[c]); end
            n_checks++; if (tr_dt[c] !== 12'(exp_row0[c])) begin n_errors++; $display("FAIL rstmid_restart_data[%0d] got %h want %h", c, tr_dt[c], 12'(exp_row0[c])); end
        end
        n_checks++; if (tr_dn[12] !== 1'b1) begin n_errors++; $display("FAIL rstmid_restart_done got %b want 1", tr_dn[12]); end
        n_checks++; if (tr_bz[14] !== 1'b0) begin n_errors++; $display("FAIL rstmid_restart_idle got %b want 0", tr_bz[14]); end
    endtask

    initial begin
        reset         = 1'b1;
        in_start      = 1'b0;
        in_continuous = 1'b0;
        in_width      = '0;
        in_height     = '0;
        in_hblank     = '0;
        in_vblank     = '0;
        test_reset;
        test_ramp_frame;
        test_min_blank;
        test_zero_size;
        test_continuous;
        test_width_change;
        test_reset_mid_line;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
